id_ex_stage: RTL and testbench

- ID/EX pipeline register placed directly upstream of the ALU in the RISC-V core.
- Captures decoded operands and control, and resolves operand forwarding at capture.
- Decodes the 4-bit ALU operation select and presents registered inp1/inp2/Op_choice to the ALU.
- Uses a valid/ready handshake with stall and flush, so hazard control can hold or kill the EX-bound instruction.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/alu_control.sv | 32 +++
 rtl/id_ex_stage.sv | 192 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared decode constants for the ID/EX stage and its ALU control decoder.
package riscv_pkg;

  // ALU operation select presented to the EX-stage ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  // Coarse ALU operation class produced by the main decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  // funct3 values understood by the funct-decoded ALU class
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU control: maps alu_op/funct3/funct7[5] onto the 4-bit ALU select.
module alu_control
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       alu_src_i,
  output logic [3:0] op_choice_o,
  output logic       illegal_o
);

  // Decode the operation; anything not understood becomes ALU_BAD with the illegal flag set
  always_comb begin
    op_choice_o = ALU_BAD;
    illegal_o   = 1'b0;
    case (alu_op_e'(alu_op_i))
      ALUOP_ADD: op_choice_o = ALU_ADD;
      ALUOP_SUB: op_choice_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          F3_ADD_SUB: op_choice_o = (funct7_5_i && !alu_src_i) ? ALU_SUB : ALU_ADD;
          F3_AND:     op_choice_o = ALU_AND;
          F3_OR:      op_choice_o = ALU_OR;
          default:    illegal_o   = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with valid/ready handshake, stall and flush.
// Operand forwarding and held-operand refresh are enabled by defining ID_EX_FWD_EN;
// without it the forwarding ports are ignored and operands come from the register file.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              alu_src,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              branch,
  input  logic              fwd_a_valid,
  input  logic              fwd_b_valid,
  input  logic [REG_AW-1:0] fwd_a_rd,
  input  logic [REG_AW-1:0] fwd_b_rd,
  input  logic [XLEN-1:0]   fwd_a_data,
  input  logic [XLEN-1:0]   fwd_b_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_inp1,
  output logic [XLEN-1:0]   alu_inp2,
  output logic [3:0]        alu_op_choice,
  output logic [XLEN-1:0]   store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              illegal_op
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   inp1_q, inp1_d;
  logic [XLEN-1:0]   inp2_q, inp2_d;
  logic [XLEN-1:0]   storeData_q, storeData_d;
  logic [3:0]        opChoice_q, opChoice_d;
  logic              illegal_q, illegal_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [4:0]        ctrl_q, ctrl_d;

  logic [3:0]        decOp;
  logic              decIllegal;
  logic              load;
  logic [XLEN-1:0]   rs1Res;
  logic [XLEN-1:0]   rs2Res;

  alu_control u_alu_control (
    .alu_op_i    (alu_op),
    .funct3_i    (funct3),
    .funct7_5_i  (funct7_5),
    .alu_src_i   (alu_src),
    .op_choice_o (decOp),
    .illegal_o   (decIllegal)
  );

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

`ifdef ID_EX_FWD_EN
  logic [REG_AW-1:0] rs1Addr_q, rs1Addr_d;
  logic [REG_AW-1:0] rs2Addr_q, rs2Addr_d;
  logic              aluSrc_q, aluSrc_d;

  // x0 reads as zero, then the younger forward (A), then the older (B), else the fallback value
  function automatic logic [XLEN-1:0] pickOperand(
    input logic [REG_AW-1:0] addr,     input logic [XLEN-1:0] fallback,
    input logic              aValid,   input logic [REG_AW-1:0] aRd, input logic [XLEN-1:0] aData,
    input logic              bValid,   input logic [REG_AW-1:0] bRd, input logic [XLEN-1:0] bData);
    if (addr == '0)                    return '0;
    else if (aValid && (aRd == addr))  return aData;
    else if (bValid && (bRd == addr))  return bData;
    else                               return fallback;
  endfunction

  assign rs1Res = pickOperand(rs1_addr, rs1_data, fwd_a_valid, fwd_a_rd, fwd_a_data,
                              fwd_b_valid, fwd_b_rd, fwd_b_data);
  assign rs2Res = pickOperand(rs2_addr, rs2_data, fwd_a_valid, fwd_a_rd, fwd_a_data,
                              fwd_b_valid, fwd_b_rd, fwd_b_data);
`else
  logic unusedFwd;
  assign unusedFwd = ^{fwd_a_valid, fwd_b_valid, fwd_a_rd, fwd_b_rd, fwd_a_data, fwd_b_data,
                       rs1_addr, rs2_addr};
  assign rs1Res = rs1_data;
  assign rs2Res = rs2_data;
`endif

  // Next-state: flush kills, load captures, consume empties, otherwise hold (refreshing forwarded operands)
  always_comb begin
    valid_d     = valid_q;
    inp1_d      = inp1_q;
    inp2_d      = inp2_q;
    storeData_d = storeData_q;
    opChoice_d  = opChoice_q;
    illegal_d   = illegal_q;
    rd_d        = rd_q;
    ctrl_d      = ctrl_q;
`ifdef ID_EX_FWD_EN
    rs1Addr_d   = rs1Addr_q;
    rs2Addr_d   = rs2Addr_q;
    aluSrc_d    = aluSrc_q;
`endif
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d     = 1'b1;
      inp1_d      = rs1Res;
      inp2_d      = alu_src ? imm : rs2Res;
      storeData_d = rs2Res;
      opChoice_d  = decOp;
      illegal_d   = decIllegal;
      rd_d        = rd_addr;
      ctrl_d      = {reg_write, mem_read, mem_write, mem_to_reg, branch};
`ifdef ID_EX_FWD_EN
      rs1Addr_d   = rs1_addr;
      rs2Addr_d   = rs2_addr;
      aluSrc_d    = alu_src;
`endif
    end else if (out_ready) begin
      valid_d = 1'b0;
`ifdef ID_EX_FWD_EN
    end else if (valid_q) begin
      inp1_d      = pickOperand(rs1Addr_q, inp1_q, fwd_a_valid, fwd_a_rd, fwd_a_data,
                                fwd_b_valid, fwd_b_rd, fwd_b_data);
      storeData_d = pickOperand(rs2Addr_q, storeData_q, fwd_a_valid, fwd_a_rd, fwd_a_data,
                                fwd_b_valid, fwd_b_rd, fwd_b_data);
      if (!aluSrc_q) inp2_d = storeData_d;
`endif
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      inp1_q      <= '0;
      inp2_q      <= '0;
      storeData_q <= '0;
      opChoice_q  <= 4'b0000;
      illegal_q   <= 1'b0;
      rd_q        <= '0;
      ctrl_q      <= '0;
`ifdef ID_EX_FWD_EN
      rs1Addr_q   <= '0;
      rs2Addr_q   <= '0;
      aluSrc_q    <= 1'b0;
`endif
    end else begin
      valid_q     <= valid_d;
      inp1_q      <= inp1_d;
      inp2_q      <= inp2_d;
      storeData_q <= storeData_d;
      opChoice_q  <= opChoice_d;
      illegal_q   <= illegal_d;
      rd_q        <= rd_d;
      ctrl_q      <= ctrl_d;
`ifdef ID_EX_FWD_EN
      rs1Addr_q   <= rs1Addr_d;
      rs2Addr_q   <= rs2Addr_d;
      aluSrc_q    <= aluSrc_d;
`endif
    end
  end

  assign out_valid     = valid_q;
  assign alu_inp1      = inp1_q;
  assign alu_inp2      = inp2_q;
  assign alu_op_choice = opChoice_q;
  assign store_data    = storeData_q;
  assign ex_rd_addr    = rd_q;
  assign {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch} = ctrl_q & {5{valid_q}};
  assign illegal_op    = illegal_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard testbench for id_ex_stage; expectations follow ID_EX_FWD_EN the same way the design does.
`timescale 1ns/1ps
module tb_id_ex_stage;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
`ifdef ID_EX_FWD_EN
   localparam logic FWD_BUILD = 1'b1;
`else
   localparam logic FWD_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] rs1_data, rs2_data, imm, fwd_a_data, fwd_b_data;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr, fwd_a_rd, fwd_b_rd;
   logic [1:0]  alu_op;
   logic [2:0]  funct3;
   logic        funct7_5, alu_src, fwd_a_valid, fwd_b_valid;
   logic        reg_write, mem_read, mem_write, mem_to_reg, branch;
   logic [31:0] alu_inp1, alu_inp2, store_data;
   logic [3:0]  alu_op_choice;
   logic [4:0]  ex_rd_addr;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, illegal_op;

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .alu_src(alu_src),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .branch(branch),
      .fwd_a_valid(fwd_a_valid), .fwd_b_valid(fwd_b_valid),
      .fwd_a_rd(fwd_a_rd), .fwd_b_rd(fwd_b_rd),
      .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_op_choice(alu_op_choice),
      .store_data(store_data), .ex_rd_addr(ex_rd_addr),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .illegal_op(illegal_op)
   );

   typedef struct {
      logic [31:0] inp1;
      logic [31:0] inp2;
      logic [31:0] store;
      logic [3:0]  op;
      logic        illegal;
      logic [4:0]  rd;
      logic [4:0]  ctrl;
      logic [4:0]  rs1a;
      logic [4:0]  rs2a;
      logic        aluSrc;
   } expItem_t;

   expItem_t scoreboard[$];
   int testCount = 0;
   int failCount = 0;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Reference ALU decode, returns {illegal, op_choice}
   function automatic logic [4:0] expDecode(input logic [1:0] op, input logic [2:0] f3,
                                            input logic f7, input logic src);
      if (op == 2'b00) return 5'b0_0010;
      if (op == 2'b01) return 5'b0_0110;
      if (op == 2'b10) begin
         if (f3 == 3'b000) return (f7 && !src) ? 5'b0_0110 : 5'b0_0010;
         if (f3 == 3'b111) return 5'b0_0000;
         if (f3 == 3'b110) return 5'b0_0001;
      end
      return 5'b1_1111;
   endfunction

   // Reference operand resolution against the currently driven forwarding ports
   function automatic logic [31:0] expOperand(input logic [4:0] addr, input logic [31:0] base);
      if (FWD_BUILD) begin
         if (addr == 5'd0) return 32'd0;
         if (fwd_a_valid && fwd_a_rd == addr) return fwd_a_data;
         if (fwd_b_valid && fwd_b_rd == addr) return fwd_b_data;
      end
      return base;
   endfunction

   task automatic clearInputs();
      in_valid = 1'b0; flush = 1'b0;
      fwd_a_valid = 1'b0; fwd_a_rd = 5'd0; fwd_a_data = 32'd0;
      fwd_b_valid = 1'b0; fwd_b_rd = 5'd0; fwd_b_data = 32'd0;
   endtask

   task automatic setInstr(input logic [1:0] op, input logic [2:0] f3, input logic f7, input logic src,
                           input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] immv,
                           input logic [4:0] ctrl);
      in_valid = 1'b1;
      alu_op = op; funct3 = f3; funct7_5 = f7; alu_src = src;
      rs1_addr = a1; rs2_addr = a2; rd_addr = rd;
      rs1_data = d1; rs2_data = d2; imm = immv;
      {reg_write, mem_read, mem_write, mem_to_reg, branch} = ctrl;
   endtask

   task automatic setFwd(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd);
      fwd_a_valid = av; fwd_a_rd = ard; fwd_a_data = ad;
      fwd_b_valid = bv; fwd_b_rd = brd; fwd_b_data = bd;
   endtask

   // One clock cycle: update the scoreboard from the driven inputs, clock, then compare
   task automatic applyStimulus(input string tag);
      expItem_t   item;
      logic       modelValid;
      logic       accept;
      logic [4:0] dec;
      #1;
      modelValid = (scoreboard.size() != 0);
      if (reset) begin
         scoreboard.delete();
      end else begin
         checkOutput({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, (!modelValid || out_ready)});
         if (modelValid && !out_ready && !flush) begin
            item = scoreboard[0];
            item.inp1  = expOperand(item.rs1a, item.inp1);
            item.store = expOperand(item.rs2a, item.store);
            if (!item.aluSrc) item.inp2 = item.store;
            scoreboard[0] = item;
         end
         accept = in_valid && (!modelValid || out_ready) && !flush;
         if (flush) begin
            scoreboard.delete();
         end else begin
            if (modelValid && out_ready) void'(scoreboard.pop_front());
            if (accept) begin
               dec          = expDecode(alu_op, funct3, funct7_5, alu_src);
               item.store   = expOperand(rs2_addr, rs2_data);
               item.inp1    = expOperand(rs1_addr, rs1_data);
               item.inp2    = alu_src ? imm : item.store;
               item.op      = dec[3:0];
               item.illegal = dec[4];
               item.rd      = rd_addr;
               item.ctrl    = {reg_write, mem_read, mem_write, mem_to_reg, branch};
               item.rs1a    = rs1_addr;
               item.rs2a    = rs2_addr;
               item.aluSrc  = alu_src;
               scoreboard.push_back(item);
            end
         end
      end
      @(posedge clk);
      #1;
      if (scoreboard.size() != 0) begin
         item = scoreboard[0];
         checkOutput({tag, ".out_valid"}, {63'd0, out_valid}, 64'd1);
         checkOutput({tag, ".inp1"}, {32'd0, alu_inp1}, {32'd0, item.inp1});
         checkOutput({tag, ".inp2"}, {32'd0, alu_inp2}, {32'd0, item.inp2});
         checkOutput({tag, ".store"}, {32'd0, store_data}, {32'd0, item.store});
         checkOutput({tag, ".op"}, {60'd0, alu_op_choice}, {60'd0, item.op});
         checkOutput({tag, ".illegal"}, {63'd0, illegal_op}, {63'd0, item.illegal});
         checkOutput({tag, ".rd"}, {59'd0, ex_rd_addr}, {59'd0, item.rd});
         checkOutput({tag, ".ctrl"},
                     {59'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch},
                     {59'd0, item.ctrl});
      end else begin
         checkOutput({tag, ".out_valid"}, {63'd0, out_valid}, 64'd0);
         checkOutput({tag, ".ctrlZero"},
                     {58'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, illegal_op},
                     64'd0);
      end
   endtask

   // Directed scenarios followed by a randomized burst
   initial begin
      clearInputs();
      setInstr(2'b00, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b1;
      applyStimulus("reset0");
      applyStimulus("reset1");
      reset = 1'b0;
      checkOutput("reset.op_choice", {60'd0, alu_op_choice}, 64'd0);
      checkOutput("reset.inp1", {32'd0, alu_inp1}, 64'd0);
      checkOutput("reset.store", {32'd0, store_data}, 64'd0);

      // add x3,x1,x2
      out_ready = 1'b1;
      setInstr(2'b10, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 5'b10000);
      applyStimulus("add");
      checkOutput("add.inp1Direct", {32'd0, alu_inp1}, 64'd5);
      checkOutput("add.inp2Direct", {32'd0, alu_inp2}, 64'd7);
      checkOutput("add.opDirect", {60'd0, alu_op_choice}, 64'd2);
      clearInputs();
      applyStimulus("drain0");

      // sub with both forward ports hitting rs1: younger (A) wins
      setInstr(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd4, 32'd11, 32'd22, 32'd0, 5'b10000);
      setFwd(1'b1, 5'd1, 32'd100, 1'b1, 5'd1, 32'd9);
      applyStimulus("subFwd");
      checkOutput("subFwd.inp1Direct", {32'd0, alu_inp1}, FWD_BUILD ? 64'd100 : 64'd11);
      checkOutput("subFwd.opDirect", {60'd0, alu_op_choice}, 64'd6);

      // x0 source never takes a forward
      setInstr(2'b00, 3'b000, 1'b0, 1'b0, 5'd0, 5'd2, 5'd5, 32'd0, 32'd3, 32'd0, 5'b10000);
      setFwd(1'b1, 5'd0, 32'd77, 1'b0, 5'd0, 32'd0);
      applyStimulus("x0");
      checkOutput("x0.inp1Direct", {32'd0, alu_inp1}, 64'd0);
      clearInputs();
      applyStimulus("drain1");

      // Hold for three cycles with a refresh of rs2 on the second
      setInstr(2'b10, 3'b000, 1'b0, 1'b0, 5'd4, 5'd5, 5'd6, 32'd40, 32'd50, 32'd0, 5'b00110);
      applyStimulus("holdLoad");
      out_ready = 1'b0;
      setInstr(2'b01, 3'b000, 1'b0, 1'b0, 5'd7, 5'd8, 5'd9, 32'd70, 32'd80, 32'd0, 5'b01010);
      applyStimulus("hold1");
      setFwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55);
      applyStimulus("hold2");
      checkOutput("hold2.inp2Direct", {32'd0, alu_inp2}, FWD_BUILD ? 64'h55 : 64'd50);
      setFwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      applyStimulus("hold3");
      out_ready = 1'b1;
      applyStimulus("release");
      checkOutput("release.inp1Direct", {32'd0, alu_inp1}, 64'd70);
      clearInputs();
      applyStimulus("drain2");

      // Flush while holding drops both the held and the incoming instruction
      setInstr(2'b00, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd10, 32'd1, 32'd2, 32'd0, 5'b10000);
      applyStimulus("flushLoad");
      out_ready = 1'b0;
      setInstr(2'b00, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd11, 32'hdead, 32'd2, 32'd0, 5'b10000);
      flush = 1'b1;
      applyStimulus("flushHold");
      checkOutput("flushHold.validDirect", {63'd0, out_valid}, 64'd0);
      out_ready = 1'b1;
      applyStimulus("flushEmpty");
      flush    = 1'b0;
      in_valid = 1'b0;
      applyStimulus("postFlush0");
      applyStimulus("postFlush1");

      // Decode corner cases back to back
      setInstr(2'b10, 3'b100, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 5'b10000);
      applyStimulus("illegal");
      checkOutput("illegal.flagDirect", {63'd0, illegal_op}, 64'd1);
      setInstr(2'b10, 3'b000, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 32'd8, 32'd9, 32'h1234, 5'b10000);
      applyStimulus("addi");
      checkOutput("addi.inp2Direct", {32'd0, alu_inp2}, 64'h1234);
      setInstr(2'b10, 3'b111, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd8, 32'd9, 32'd0, 5'b10000);
      applyStimulus("and");
      setInstr(2'b10, 3'b110, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd8, 32'd9, 32'd0, 5'b10000);
      applyStimulus("or");
      setInstr(2'b11, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd8, 32'd9, 32'd0, 5'b00001);
      applyStimulus("rsvd");
      setInstr(2'b01, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd12, 32'd8, 32'd9, 32'd0, 5'b01100);
      applyStimulus("beq");
      clearInputs();
      applyStimulus("drain3");

      // Reset while stalled clears the held instruction
      setInstr(2'b00, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd13, 32'd3, 32'd4, 32'd0, 5'b10000);
      applyStimulus("rstLoad");
      out_ready = 1'b0;
      in_valid  = 1'b0;
      applyStimulus("rstHold");
      reset = 1'b1;
      applyStimulus("rstMid");
      reset = 1'b0;
      checkOutput("rstMid.validDirect", {63'd0, out_valid}, 64'd0);

      // Randomized traffic with stalls, forwards and occasional flush
      for (int i = 0; i < 60; i++) begin
         setInstr(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
         in_valid  = 1'($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         setFwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
         applyStimulus("rand");
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
